// File: rtl/program_loader.sv
// Writer side of the MiniAlu instruction memory: turns a framed, checksummed byte
// stream into 28-bit program-RAM writes and holds the CPU in reset until a frame verifies.
module program_loader #(
  parameter int          ADDR_W  = 16,
  parameter int          TIMEOUT = 1000,
  parameter logic [7:0]  HEADER  = 8'hA5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [7:0]        iByte,
  input  logic              iByteValid,
  output logic              oByteReady,
  output logic              oWriteEnable,
  output logic [ADDR_W-1:0] oWriteAddress,
  output logic [27:0]       oWriteData,
  output logic              oCpuHold,
  output logic              oDone,
  output logic              oError,
  output logic [2:0]        oDebugState
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_e;

  // Handshake: a byte transfers on a posedge where iByteValid and oByteReady are both 1;
  // oByteReady is registered, so it already reflects the state the byte will land in.
  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [27:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [7:0]        chk_q, chk_d;
  logic [7:0]        n_q, n_d;
  logic [7:0]        words_q, words_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [TW-1:0]     idle_q, idle_d;

  logic xfer;
  logic hdr;
  logic timed_out;

  assign xfer      = iByteValid & ready_q;
  assign hdr       = xfer && (iByte == HEADER);
  assign timed_out = (idle_q == TW'(TIMEOUT - 1));

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      chk_q   <= '0;
      n_q     <= '0;
      words_q <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      error_q <= error_d;
      chk_q   <= chk_d;
      n_q     <= n_d;
      words_q <= words_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    error_d = error_q;
    chk_d   = chk_q;
    n_d     = n_q;
    words_d = words_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    idle_d  = idle_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (hdr) begin
          state_d = S_COUNT;
          error_d = 1'b0;
          addr_d  = '0;
          chk_d   = '0;
          words_d = '0;
          bcnt_d  = '0;
          idle_d  = '0;
        end
      end
      S_COUNT: begin
        if (xfer) begin
          idle_d = '0;
          if (iByte == 8'h00) begin
            state_d = S_ERROR;
          end else begin
            n_d     = iByte;
            state_d = S_DATA;
          end
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_DATA: begin
        if (xfer) begin
          idle_d  = '0;
          shift_d = {shift_q[15:0], iByte};
          chk_d   = chk_q ^ iByte;
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == 2'd3) begin
            // Top nibble of the first byte is dropped to form the 28-bit word.
            wdata_d = {shift_q[19:0], iByte};
            state_d = S_WRITE;
          end
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 1'b1;
        words_d = words_q + 8'd1;
        idle_d  = '0;
        state_d = ((words_q + 8'd1) == n_q) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        if (xfer) begin
          idle_d  = '0;
          state_d = (iByte == chk_q) ? S_DONE : S_ERROR;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ERROR) error_d = 1'b1;
    ready_d = (state_d != S_WRITE) && (state_d != S_ERROR);
    we_d    = (state_d == S_WRITE);
    hold_d  = (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
  end

  assign oByteReady    = ready_q;
  assign oWriteEnable  = we_q;
  assign oWriteAddress = addr_q;
  assign oWriteData    = wdata_q;
  assign oCpuHold      = hold_q;
  assign oDone         = done_q;
  assign oError        = error_q;
  assign oDebugState   = state_q;

endmodule
